// File: rtl/line_mem_responder_if.sv
// Request/response bundle between a cache (master) and its line/word backing memory (slave).
// Requests are level-sensitive; completion is the mem_done pulse.
interface line_mem_responder_if #(
  parameter int ADDR_SIZE  = 10,
  parameter int LINE_WORDS = 4
);
  logic [ADDR_SIZE-1:0]        mem_addr;
  logic [LINE_WORDS-1:0][31:0] line_store;
  logic                        mem_w_line;
  logic                        mem_r_line;
  logic                        mem_w_one;
  logic                        mem_r_one;
  logic [LINE_WORDS-1:0][31:0] line_read;
  logic                        mem_ready;
  logic                        mem_done;
  logic                        req_err;

  modport master (
    output mem_addr, line_store, mem_w_line, mem_r_line, mem_w_one, mem_r_one,
    input  line_read, mem_ready, mem_done, req_err
  );

  modport slave (
    input  mem_addr, line_store, mem_w_line, mem_r_line, mem_w_one, mem_r_one,
    output line_read, mem_ready, mem_done, req_err
  );
endinterface

// File: rtl/line_mem_responder.sv
// Memory-side responder: serves one line/word read or write at a time from a word-wide array,
// one word per slot of ACCESS_LAT+1 cycles, then pulses mem_done and waits for the request to drop.
module line_mem_responder #(
  parameter int ADDR_SIZE  = 10,
  parameter int LINE_WORDS = 4,
  parameter int ACCESS_LAT = 1
) (
  input logic                 clk,
  input logic                 rst_l,
  line_mem_responder_if.slave bus
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int DEPTH = 2 ** ADDR_SIZE;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] REL  = 2'd3;

  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);
  localparam logic [2:0]       LAST_WAIT = 3'(ACCESS_LAT);

  logic [1:0]                  state_reg;
  logic [1:0]                  state_next;
  logic [ADDR_SIZE-1:0]        addr_reg;
  logic                        is_line_reg;
  logic                        is_write_reg;
  logic [LINE_WORDS-1:0][31:0] store_reg;
  logic [LINE_WORDS-1:0][31:0] line_read_reg;
  logic [2:0]                  wait_reg;
  logic [OFF_W-1:0]            word_reg;
  logic                        err_reg;

  logic [31:0] mem [DEPTH];

  logic [3:0]            req;
  logic                  any_req;
  logic                  multi_req;
  logic                  accept;
  logic                  slot_end;
  logic                  last_slot;
  logic                  access_we;
  logic                  access_re;
  logic [ADDR_SIZE-1:0]  access_addr;
  logic [31:0]           rd_word;
  logic [LINE_WORDS-1:0] rd_sel;

  assign req       = {bus.mem_w_line, bus.mem_r_line, bus.mem_w_one, bus.mem_r_one};
  assign any_req   = |req;
  assign multi_req = $countones(req) > 1;
  assign accept    = (state_reg == IDLE) && any_req;

  // The access happens on the last cycle of each slot; word ops have a single slot.
  assign slot_end  = (state_reg == BUSY) && (wait_reg == LAST_WAIT);
  assign last_slot = !is_line_reg || (word_reg == LAST_WORD);
  assign access_we = slot_end && is_write_reg;
  assign access_re = slot_end && !is_write_reg;

  // Line base is aligned, so a line never wraps past the top of the array.
  assign access_addr = is_line_reg ? {addr_reg[ADDR_SIZE-1:OFF_W], word_reg} : addr_reg;
  assign rd_word     = mem[access_addr];

  // Word ops keep word_reg at 0, so they land in element [0] without special casing.
  for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_rd_sel
    assign rd_sel[gi] = access_re && (word_reg == OFF_W'(gi));
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req) state_next = BUSY;
      BUSY:    if (slot_end && last_slot) state_next = DONE;
      DONE:    state_next = REL;
      REL:     if (!any_req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      is_line_reg  <= 1'b0;
      is_write_reg <= 1'b0;
      store_reg    <= '0;
      wait_reg     <= '0;
      word_reg     <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= accept && multi_req;
      if (accept) begin
        // Priority w_line > r_line > w_one > r_one.
        addr_reg     <= bus.mem_addr;
        is_line_reg  <= bus.mem_w_line || bus.mem_r_line;
        is_write_reg <= bus.mem_w_line || (!bus.mem_r_line && bus.mem_w_one);
        store_reg    <= bus.line_store;
        wait_reg     <= '0;
        word_reg     <= '0;
      end else if (state_reg == BUSY) begin
        if (slot_end) begin
          wait_reg <= '0;
          if (!last_slot) word_reg <= word_reg + OFF_W'(1);
        end else begin
          wait_reg <= wait_reg + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      line_read_reg <= '0;
    end else begin
      for (int k = 0; k < LINE_WORDS; k++) begin
        if (rd_sel[k]) line_read_reg[k] <= rd_word;
      end
    end
  end

  // Array contents survive reset; an interrupted line write keeps the words already stored.
  always_ff @(posedge clk) begin
    if (access_we) mem[access_addr] <= store_reg[word_reg];
  end

  assign bus.mem_ready = (state_reg == IDLE);
  assign bus.mem_done  = (state_reg == DONE);
  assign bus.req_err   = err_reg;
  assign bus.line_read = line_read_reg;
endmodule

// File: tb/tb_line_mem_responder.sv
// Self-checking bench: a slow (ACCESS_LAT=1) responder driven from a vector table plus a
// mid-write reset sequence, and a fast (ACCESS_LAT=0) responder driven with random word ops.
module tb_line_mem_responder;
  localparam int AW = 10;
  localparam int LW = 4;

  typedef logic [LW-1:0][31:0] line_t;

  typedef struct {
    logic [3:0]    req;
    logic [AW-1:0] addr;
    line_t         data;
    int            hold;
    int            exp_busy;
    int            exp_err;
    line_t         exp_read;
  } vec_t;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  line_mem_responder_if #(.ADDR_SIZE(AW), .LINE_WORDS(LW)) bs ();
  line_mem_responder_if #(.ADDR_SIZE(AW), .LINE_WORDS(LW)) bf ();

  line_mem_responder #(.ADDR_SIZE(AW), .LINE_WORDS(LW), .ACCESS_LAT(1)) dut_slow (
    .clk(clk), .rst_l(rst_l), .bus(bs.slave)
  );
  line_mem_responder #(.ADDR_SIZE(AW), .LINE_WORDS(LW), .ACCESS_LAT(0)) dut_fast (
    .clk(clk), .rst_l(rst_l), .bus(bf.slave)
  );

  int    total = 0;
  int    bad = 0;
  bit    use_fast = 1'b0;
  line_t exp_q[$];
  vec_t  vecs[10];

  logic  obs_ready, obs_done, obs_err;
  line_t obs_read;
  assign obs_ready = use_fast ? bf.mem_ready : bs.mem_ready;
  assign obs_done  = use_fast ? bf.mem_done  : bs.mem_done;
  assign obs_err   = use_fast ? bf.req_err   : bs.req_err;
  assign obs_read  = use_fast ? bf.line_read : bs.line_read;

  function automatic line_t mk(input logic [31:0] w3, input logic [31:0] w2,
                               input logic [31:0] w1, input logic [31:0] w0);
    return {w3, w2, w1, w0};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] req, input logic [AW-1:0] addr, input line_t data);
    if (use_fast) begin
      bf.mem_w_line = req[3]; bf.mem_r_line = req[2];
      bf.mem_w_one  = req[1]; bf.mem_r_one  = req[0];
      bf.mem_addr   = addr;   bf.line_store = data;
    end else begin
      bs.mem_w_line = req[3]; bs.mem_r_line = req[2];
      bs.mem_w_one  = req[1]; bs.mem_r_one  = req[0];
      bs.mem_addr   = addr;   bs.line_store = data;
    end
  endtask

  // One full handshake; exp_read is the line_read value required while mem_done is high.
  task automatic run_op(input string tag, input logic [3:0] req, input logic [AW-1:0] addr,
                        input line_t data, input int hold, input int exp_busy,
                        input int exp_err, input line_t exp_read);
    int    busy, dones, errs;
    bit    got;
    line_t e;
    @(negedge clk);
    check({tag, "/ready_idle"}, 128'(obs_ready), 128'(1));
    exp_q.push_back(exp_read);
    drive(req, addr, data);
    busy = 0; dones = 0; errs = 0; got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (obs_err) errs++;
      if (obs_done) begin
        got = 1'b1;
        dones++;
      end else begin
        busy++;
        drive(req, ~addr, ~data);  // latched values must be used
      end
    end
    check({tag, "/done_seen"}, 128'(got), 128'(1));
    check({tag, "/busy_cycles"}, 128'(busy), 128'(exp_busy));
    if (got && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "/line_read"}, obs_read, e);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (obs_done) dones++;
      check({tag, "/held_not_ready"}, 128'(obs_ready), 128'(0));
    end
    drive(4'b0000, addr, data);
    @(negedge clk);
    if (obs_done) dones++;
    if (obs_err) errs++;
    if (hold > 0) check({tag, "/ready_after_drop"}, 128'(obs_ready), 128'(1));
    for (int c = 0; c < 8 && !obs_ready; c++) begin
      @(negedge clk);
      if (obs_done) dones++;
    end
    check({tag, "/ready_return"}, 128'(obs_ready), 128'(1));
    check({tag, "/done_pulses"}, 128'(dones), 128'(1));
    check({tag, "/err_pulses"}, 128'(errs), 128'(exp_err));
    check({tag, "/read_stable"}, obs_read, exp_read);
    $display("op %s req=%b addr=%h busy=%0d done=%0d err=%0d read=%h",
             tag, req, addr, busy, dones, errs, obs_read);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    line_t         fast_lr;
    logic [31:0]   model [1024];
    logic [AW-1:0] waddr [5];
    logic [31:0]   wdata;
    logic [AW-1:0] a;

    use_fast = 1'b1; drive(4'b0000, '0, '0);
    use_fast = 1'b0; drive(4'b0000, '0, '0);

    vecs[0] = '{4'b1000, 10'h013, mk(32'h44, 32'h33, 32'h22, 32'h11), 0, 8, 0, line_t'(0)};
    vecs[1] = '{4'b0100, 10'h010, line_t'(0), 0, 8, 0, mk(32'h44, 32'h33, 32'h22, 32'h11)};
    vecs[2] = '{4'b0010, 10'h011, mk(32'h1, 32'h2, 32'h3, 32'hDEADBEEF), 0, 2, 0,
                mk(32'h44, 32'h33, 32'h22, 32'h11)};
    vecs[3] = '{4'b0100, 10'h012, line_t'(0), 0, 8, 0, mk(32'h44, 32'h33, 32'hDEADBEEF, 32'h11)};
    vecs[4] = '{4'b0001, 10'h011, line_t'(0), 0, 2, 0,
                mk(32'h44, 32'h33, 32'hDEADBEEF, 32'hDEADBEEF)};
    vecs[5] = '{4'b0110, 10'h011, mk(32'h0, 32'h0, 32'h0, 32'h12345678), 0, 8, 1,
                mk(32'h44, 32'h33, 32'hDEADBEEF, 32'h11)};
    vecs[6] = '{4'b0001, 10'h011, line_t'(0), 0, 2, 0,
                mk(32'h44, 32'h33, 32'hDEADBEEF, 32'hDEADBEEF)};
    vecs[7] = '{4'b1000, 10'h3FE, mk(32'hA4, 32'hA3, 32'hA2, 32'hA1), 5, 8, 0,
                mk(32'h44, 32'h33, 32'hDEADBEEF, 32'hDEADBEEF)};
    vecs[8] = '{4'b0100, 10'h3FC, line_t'(0), 0, 8, 0, mk(32'hA4, 32'hA3, 32'hA2, 32'hA1)};
    vecs[9] = '{4'b0100, 10'h013, line_t'(0), 0, 8, 0, mk(32'h44, 32'h33, 32'hDEADBEEF, 32'h11)};

    repeat (3) @(negedge clk);
    check("rst_ready_slow", 128'(bs.mem_ready), 128'(1));
    check("rst_done_slow", 128'(bs.mem_done), 128'(0));
    check("rst_err_slow", 128'(bs.req_err), 128'(0));
    check("rst_read_slow", bs.line_read, '0);
    check("rst_ready_fast", 128'(bf.mem_ready), 128'(1));
    check("rst_read_fast", bf.line_read, '0);
    rst_l = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].data, vecs[i].hold,
             vecs[i].exp_busy, vecs[i].exp_err, vecs[i].exp_read);
    end

    // Reset in the middle of a line write: words 0 and 1 stay written.
    run_op("zero_line", 4'b1000, 10'h020, line_t'(0), 0, 8, 0,
           mk(32'h44, 32'h33, 32'hDEADBEEF, 32'h11));
    @(negedge clk);
    drive(4'b1000, 10'h020, mk(32'd4, 32'd3, 32'd2, 32'd1));
    repeat (5) @(negedge clk);
    rst_l = 1'b0;
    #1;
    check("midrst_ready", 128'(obs_ready), 128'(1));
    check("midrst_done", 128'(obs_done), 128'(0));
    check("midrst_err", 128'(obs_err), 128'(0));
    check("midrst_read", obs_read, '0);
    $display("op midrst addr=020 ready=%0d read=%h", obs_ready, obs_read);
    drive(4'b0000, '0, '0);
    @(negedge clk);
    rst_l = 1'b1;
    run_op("rst_readback", 4'b0100, 10'h020, line_t'(0), 0, 8, 0,
           mk(32'd0, 32'd0, 32'd2, 32'd1));

    // Zero-latency responder: back-to-back random word ops against a model array.
    use_fast = 1'b1;
    fast_lr = '0;
    for (int i = 0; i < 10; i++) begin
      if (i < 5) begin
        a = AW'($urandom_range(0, 1023));
        wdata = $urandom;
        waddr[i] = a;
        model[a] = wdata;
        run_op($sformatf("fast_w%0d", i), 4'b0010, a,
               mk($urandom, $urandom, $urandom, wdata), 0, 1, 0, fast_lr);
      end else begin
        a = waddr[((i - 5) * 3) % 5];
        fast_lr[0] = model[a];
        run_op($sformatf("fast_r%0d", i), 4'b0001, a, line_t'(0), 0, 1, 0, fast_lr);
      end
    end

    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
